// File: rtl/fetch_buffer.sv
// fetch_buffer -- decode-side packet FIFO between fetch and decode.
//
// Captures {pc[63:32], instruction[31:0]} packets from fetch into a
// DEPTH-entry FIFO and presents the oldest entry to decode through a
// valid/ready handshake. stall is raised while SKID free slots still
// remain, so the one packet fetch has in flight when it sees stall can
// still be absorbed. flush discards every buffered packet.
//
// Optional feature (compile-time macro FETCH_BUFFER_BYPASS_EN):
//   When defined, a packet arriving at an empty buffer is shown to decode
//   in the same cycle. If decode takes it, it is never written.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   SKID   free slots left when stall asserts (1 <= SKID < DEPTH)
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   fetch_valid         fetch_data holds a valid packet
//   fetch_data[63:0]    {pc, instruction} from fetch
//   flush               discard all entries, dominates all other events
//   stall               backpressure to fetch / PC generator
//   decode_valid        head entry available
//   decode_ready        decode accepts the head entry this cycle
//   decode_pc[31:0]     pc of head entry
//   decode_instruction  instruction of head entry
//   count               number of occupied entries
//   overflow            sticky: a packet was dropped (cleared by flush)
module fetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SKID  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fetch_valid,
    input  logic [63:0]              fetch_data,
    input  logic                     flush,
    output logic                     stall,
    output logic                     decode_valid,
    input  logic                     decode_ready,
    output logic [31:0]              decode_pc,
    output logic [31:0]              decode_instruction,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] C_STALL_AT = CW'(DEPTH - SKID);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_bypass;
    logic          w_bypass_take;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;
    logic [63:0]   w_head;

    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == C_DEPTH);

`ifdef FETCH_BUFFER_BYPASS_EN
        w_bypass = w_empty && fetch_valid && !flush;
`else
        w_bypass = 1'b0;
`endif
        // A bypassed packet taken by decode never enters storage.
        w_bypass_take = w_bypass && decode_ready;

        w_pop  = !w_empty && !flush && decode_ready;
        // Popping frees a slot in the same cycle, so a full buffer can
        // still accept when the head leaves.
        w_push = fetch_valid && !flush && !w_bypass_take && (!w_full || w_pop);
        w_drop = fetch_valid && !flush && w_full && !w_pop;

        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end

    always_comb begin
        w_head = r_mem[r_rd_ptr];
`ifdef FETCH_BUFFER_BYPASS_EN
        if (w_bypass) begin
            w_head = fetch_data;
        end
`endif
    end

    assign decode_valid       = (!w_empty && !flush) || w_bypass;
    assign decode_pc          = w_head[63:32];
    assign decode_instruction = w_head[31:0];
    // Registered count only: no combinational path from the handshakes.
    assign stall              = (r_count >= C_STALL_AT);
    assign count              = r_count;
    assign overflow           = r_overflow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= fetch_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            // Storage is left as-is; resetting the pointers is enough.
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
Decode-side reader for the fetch stage's 64-bit packet: {pc[63:32], instruction[31:0]}.
- Captures each valid packet into a DEPTH-entry FIFO.
- Presents the oldest entry to decode with a valid/ready handshake.
- Drives stall back to the fetch/PC logic; the stall margin absorbs the one-cycle in-flight packet that fetch produces after a stall is raised.
- flush (branch/exception redirect) discards all buffered packets.

Parameters:
- DEPTH, 4: number of entries; power of two, >= 2.
- SKID, 1: free slots still remaining when stall asserts; 1 <= SKID < DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- fetch_valid  input  1  fetch_data holds a valid packet this cycle.
- fetch_data  input  64  {pc, instruction} from fetch.
- flush  input  1  discard all entries; dominates every other event in that cycle.
- stall  output  1  backpressure to fetch/PC generator.
- decode_valid  output  1  head entry available.
- decode_ready  input  1  decode accepts head entry this cycle.
- decode_pc  output  32  pc of head entry.
- decode_instruction  output  32  instruction of head entry.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- overflow  output  1  sticky: a packet was dropped.

Behaviour:
- Reset (reset_n=0, asynchronous): count=0, read/write pointers=0, all storage=0, overflow=0. Hence decode_valid=0, decode_pc=0, decode_instruction=0 and stall=0 while reset is held and after release.
- Storage: DEPTH x 64 registers. Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- decode_valid = (count != 0) && !flush. It is combinational from registered state and flush only.
- decode_pc / decode_instruction = storage[rd_ptr][63:32] / [31:0]. These are driven even when decode_valid=0; consumers ignore them then.
- pop = decode_valid && decode_ready. At the clock edge rd_ptr advances by 1.
- push = fetch_valid && !flush && (count < DEPTH || pop). At the clock edge the packet is written at wr_ptr and wr_ptr advances by 1.
- When full, pop-then-push in the same cycle is legal; count stays at DEPTH.
- count next value = count + push - pop.
- Latency: a packet pushed at edge N is visible on decode_* after edge N, i.e. one cycle. Packets leave in strict FIFO order.
- stall = (count >= DEPTH - SKID). It is a function of registered count only, with no combinational path from fetch_valid or decode_ready.
- Drop rule: fetch_valid && !flush && count==DEPTH && !pop means the packet is discarded and overflow sets at the edge.
  - overflow clears only on reset or flush.
  - With correct SKID usage this never occurs; its occurrence is a design error.
- Flush: at the edge with flush=1, count←0 and rd_ptr=wr_ptr←0; storage is left unchanged.
  - No push and no pop occur in that cycle, regardless of fetch_valid/decode_ready.
  - decode_valid is 0 during the flush cycle. The packet arriving in the cycle after flush is accepted normally.
- Empty with simultaneous fetch_valid (no bypass): push only. decode_valid stays 0 that cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight packets are lost.

Optional Feature:
- Macro: FETCH_BUFFER_BYPASS_EN.
- Defined: when count==0 && fetch_valid && !flush, decode_valid=1 in the same cycle and decode_pc/decode_instruction = fetch_data fields.
  - If decode_ready=1, the packet is consumed and not written; count stays 0.
  - If decode_ready=0, the packet is written as normal and becomes the head next cycle.
  - This adds a combinational path fetch_valid/fetch_data -> decode_*. stall is unchanged.
- Undefined: no bypass; minimum latency is one cycle as above.

Test Plan:
- Reset release, then single packet: fetch_valid=1 with pc=0x100, instr=0x00000013 for one cycle, decode_ready=1 → next cycle decode_valid=1, decode_pc=0x100, decode_instruction=0x00000013; the cycle after, count=0 and decode_valid=0.
- Fill and stall (DEPTH=4, SKID=1): decode_ready=0, push pc 0x0,0x4,0x8 → stall=1 once count=3. A fourth in-flight packet 0xC is accepted (count=4, overflow=0). A fifth packet 0x10 is dropped and overflow=1.
- Full with simultaneous push/pop: count=4, fetch_valid=1 (pc 0x10), decode_ready=1 → head 0x0 popped and 0x10 written; count remains 4. Drain order is 0x4, 0x8, 0xC, 0x10.
- Flush: count=3, flush=1 with fetch_valid=1 and decode_ready=1 → decode_valid=0 that cycle; next cycle count=0, overflow=0, stall=0, and the flush-cycle packet is absent. A packet pc=0x200 the following cycle appears one cycle later.
- Pointer wrap: stream 10 packets at pc 0x0..0x24 (step 4) with decode_ready toggling 1,0,1,0… → all 10 delivered in order, no drop, count never exceeds 4.
- Async reset mid-stream: count=2, drive reset_n=0 between clock edges → count=0, decode_valid=0, stall=0 immediately. After release, the first new packet is delivered correctly. With FETCH_BUFFER_BYPASS_EN, an empty buffer with fetch_valid=1 and decode_ready=1 shows decode_valid=1 in the same cycle and count stays 0.
